// File: rtl/snail_scan_ctrl.sv
// snail_scan_ctrl
// ---------------
// Word-to-serial sequencer around a "two consecutive ones" detector.
// A word accepted over the start handshake is shifted out MSB-first, one
// bit per clock, through a SAD/HOPE/HOORAY detector.
// Every entry into HOORAY is counted as one hit, so "111" counts twice.
// The hit count is reported when the scan finishes.
//
// Ports:
//   clk      : clock, all state updates on the rising edge
//   _rst     : asynchronous reset, active-low
//   start    : request a scan of data_in (accepted only while ready)
//   abort    : cancel a scan in progress (SHIFT or DONE)
//   data_in  : word to scan, sampled on the accepting edge only
//   ready    : controller idle, a start will be accepted
//   busy     : scan in progress
//   done     : one-cycle pulse, hits/found are final
//   hits     : number of overlapping "11" pairs in the last word (saturating)
//   found    : hits != 0
module snail_scan_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             _rst,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] data_in,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] hits,
    output logic             found
);

    localparam int BCW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SAD    = 2'd0,
        HOPE   = 2'd1,
        HOORAY = 2'd2
    } det_t;

    state_t           state, state_nxt;
    det_t             det, det_nxt;
    logic [WIDTH-1:0] sreg, sreg_nxt;
    logic [BCW-1:0]   bcnt, bcnt_nxt;
    logic [CNT_W-1:0] hit_cnt, hit_cnt_nxt;
    logic             found_q, found_nxt;
    logic             cur_bit;

    assign cur_bit = sreg[WIDTH-1];

    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            state   <= IDLE;
            det     <= SAD;
            sreg    <= '0;
            bcnt    <= '0;
            hit_cnt <= '0;
            found_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            det     <= det_nxt;
            sreg    <= sreg_nxt;
            bcnt    <= bcnt_nxt;
            hit_cnt <= hit_cnt_nxt;
            found_q <= found_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        det_nxt     = det;
        sreg_nxt    = sreg;
        bcnt_nxt    = bcnt;
        hit_cnt_nxt = hit_cnt;
        found_nxt   = found_q;

        case (state)
            IDLE: begin
                // abort is meaningless here, so start alone decides
                if (start) begin
                    sreg_nxt    = data_in;
                    hit_cnt_nxt = '0;
                    found_nxt   = 1'b0;
                    det_nxt     = SAD;
                    bcnt_nxt    = '0;
                    state_nxt   = SHIFT;
                end
            end

            SHIFT: begin
                if (abort) begin
                    hit_cnt_nxt = '0;
                    found_nxt   = 1'b0;
                    state_nxt   = IDLE;
                end else begin
                    sreg_nxt = {sreg[WIDTH-2:0], 1'b0};
                    bcnt_nxt = bcnt + 1'b1;
                    if (!cur_bit) begin
                        det_nxt = SAD;
                    end else if (det == SAD) begin
                        det_nxt = HOPE;
                    end else begin
                        // HOPE->HOORAY and HOORAY->HOORAY both count as a hit
                        det_nxt   = HOORAY;
                        found_nxt = 1'b1;
                        if (hit_cnt != {CNT_W{1'b1}}) begin
                            hit_cnt_nxt = hit_cnt + 1'b1;
                        end
                    end
                    // bcnt holds the index of the bit consumed on this edge
                    if (bcnt == BCW'(WIDTH - 1)) begin
                        state_nxt = DONE;
                    end
                end
            end

            DONE: begin
                state_nxt = IDLE;
                if (abort) begin
                    hit_cnt_nxt = '0;
                    found_nxt   = 1'b0;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign ready = (state == IDLE);
    assign busy  = (state == SHIFT);
    assign done  = (state == DONE);
    assign hits  = hit_cnt;
    assign found = found_q;

endmodule

// File: tb/tb_snail_scan_ctrl.sv
module tb_snail_scan_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start8, abort8;
    logic [7:0] data8;
    logic       ready8, busy8, done8, found8;
    logic [3:0] hits8;

    logic       start4, abort4;
    logic [3:0] data4;
    logic       ready4, busy4, done4, found4;
    logic [1:0] hits4;

    int checks   = 0;
    int failures = 0;

    snail_scan_ctrl #(.WIDTH(8), .CNT_W(4)) dut8 (
        .clk(clk), ._rst(rst_n), .start(start8), .abort(abort8), .data_in(data8),
        .ready(ready8), .busy(busy8), .done(done8), .hits(hits8), .found(found8)
    );

    snail_scan_ctrl #(.WIDTH(4), .CNT_W(2)) dut4 (
        .clk(clk), ._rst(rst_n), .start(start4), .abort(abort4), .data_in(data4),
        .ready(ready4), .busy(busy4), .done(done4), .hits(hits4), .found(found4)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic report_timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s: timeout waiting on DUT at %0t", name, $time);
    endtask

    // ---------------- behavioural model ----------------
    // mode: 0 idle, 1 scanning, 2 done cycle. k = bits of word consumed so far.
    // Expected hits = overlapping "11" pairs among the consumed MSB bits.
    int         m_mode[2] = '{0, 0};
    int         m_k[2]    = '{0, 0};
    logic [7:0] m_word[2] = '{8'h00, 8'h00};

    function automatic int pairs(input logic [7:0] w, input int width, input int k, input int maxv);
        int n = 0;
        for (int b = width - 1; b >= width - k + 1; b--) begin
            if (w[b] && w[b-1]) n++;
        end
        return (n > maxv) ? maxv : n;
    endfunction

    task automatic model_step(input int i, input logic s, input logic a,
                              input logic [7:0] d, input int width);
        case (m_mode[i])
            0: if (s) begin
                m_word[i] = d;
                m_k[i]    = 0;
                m_mode[i] = 1;
            end
            1: if (a) begin
                m_mode[i] = 0;
                m_k[i]    = 0;
            end else begin
                m_k[i]++;
                if (m_k[i] == width) m_mode[i] = 2;
            end
            default: begin
                if (a) m_k[i] = 0;
                m_mode[i] = 0;
            end
        endcase
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_mode[i] = 0;
                m_k[i]    = 0;
            end
        end else begin
            model_step(0, start8, abort8, data8, 8);
            model_step(1, start4, abort4, {4'b0, data4}, 4);
        end
    end

    task automatic cmp_inst(input int i, input string tag, input logic r, input logic b,
                            input logic d, input logic [3:0] h, input logic f,
                            input int width, input int maxv);
        int eh;
        eh = pairs(m_word[i], width, m_k[i], maxv);
        check({tag, "_ready"}, r, m_mode[i] == 0);
        check({tag, "_busy"},  b, m_mode[i] == 1);
        check({tag, "_done"},  d, m_mode[i] == 2);
        check({tag, "_hits"},  h, eh);
        check({tag, "_found"}, f, eh != 0);
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            cmp_inst(0, "w8", ready8, busy8, done8, hits8, found8, 8, 15);
            cmp_inst(1, "w4", ready4, busy4, done4, {2'b0, hits4}, found4, 4, 3);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic start_scan(input int i, input logic [7:0] w);
        int n = 0;
        while (((i == 0) ? ready8 : ready4) !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) report_timeout("start_ready");
        if (i == 0) begin start8 = 1'b1; data8 = w; end
        else        begin start4 = 1'b1; data4 = w[3:0]; end
        @(negedge clk);
        // data changes while busy must be ignored
        if (i == 0) begin start8 = 1'b0; data8 = 8'($urandom); end
        else        begin start4 = 1'b0; data4 = 4'($urandom); end
    endtask

    // Cycle numbering: the cycle with start high is 0; returns the cycle done is seen.
    task automatic wait_done(input int i, output int cyc);
        cyc = 1;
        while (((i == 0) ? done8 : done4) !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 40) report_timeout("wait_done");
    endtask

    initial begin
        int cyc;
        rst_n  = 1'b0;
        start8 = 1'b0; abort8 = 1'b0; data8 = 8'h00;
        start4 = 1'b0; abort4 = 1'b0; data4 = 4'h0;
        #2;
        check("rst_ready8", ready8, 1);
        check("rst_busy8",  busy8,  0);
        check("rst_done8",  done8,  0);
        check("rst_hits8",  hits8,  0);
        check("rst_found8", found8, 0);
        check("rst_ready4", ready4, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // all ones: 7 overlapping hits, done after WIDTH shift cycles
        start_scan(0, 8'hFF);
        wait_done(0, cyc);
        check("ff_done_cycle", cyc, 9);
        check("ff_hits", hits8, 7);
        check("ff_found", found8, 1);
        @(negedge clk);
        check("ff_done_pulse_len", done8, 0);

        // alternating bits: no hits
        start_scan(0, 8'hAA);
        wait_done(0, cyc);
        check("aa_done_cycle", cyc, 9);
        check("aa_hits", hits8, 0);
        check("aa_found", found8, 0);

        // back to back, restarted on the first ready cycle
        start_scan(0, 8'h66);
        wait_done(0, cyc);
        check("x66_hits", hits8, 2);
        start_scan(0, 8'hC0);
        wait_done(0, cyc);
        check("xc0_hits", hits8, 1);
        check("xc0_found", found8, 1);

        // start while busy is ignored
        start_scan(0, 8'hFF);
        @(negedge clk);
        start8 = 1'b1; data8 = 8'h00;
        @(negedge clk);
        start8 = 1'b0;
        wait_done(0, cyc);
        check("ign_hits", hits8, 7);
        check("ign_ready_in_done", ready8, 0);

        // abort in the 4th shift cycle
        start_scan(0, 8'hFF);
        repeat (3) @(negedge clk);
        abort8 = 1'b1;
        @(negedge clk);
        abort8 = 1'b0;
        check("abort_ready", ready8, 1);
        check("abort_hits", hits8, 0);
        check("abort_found", found8, 0);
        repeat (10) @(negedge clk);

        // asynchronous reset mid-scan
        start_scan(0, 8'hFF);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_ready", ready8, 1);
        check("arst_busy",  busy8,  0);
        check("arst_hits",  hits8,  0);
        check("arst_found", found8, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);

        // narrow instance: 4 ones -> 3 hits, fits in 2 bits
        start_scan(1, 8'h0F);
        wait_done(1, cyc);
        check("w4_done_cycle", cyc, 5);
        check("w4_hits", hits4, 3);
        check("w4_found", found4, 1);
        @(negedge clk);

        // randomized traffic on both instances
        repeat (800) begin
            start8 = ($urandom_range(0, 3) == 0);
            abort8 = ($urandom_range(0, 15) == 0);
            data8  = 8'($urandom);
            start4 = ($urandom_range(0, 3) == 0);
            abort4 = ($urandom_range(0, 15) == 0);
            data4  = 4'($urandom);
            @(negedge clk);
        end
        start8 = 1'b0; abort8 = 1'b0;
        start4 = 1'b0; abort4 = 1'b0;
        repeat (12) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/snail_scan_ctrl.md
Name: snail_scan_ctrl

Overview:
Sequencer for the "two consecutive ones" serial detector (SAD/HOPE/HOORAY behaviour).
- Accepts a parallel word over a start/done handshake.
- Serialises the word MSB-first, one bit per clock, through an embedded detector.
- Counts detector hits and reports the count.
- Sits between a word-oriented producer (CPU/bus register) and the bit-serial detection datapath.

Parameters:
WIDTH, 8, bits per scanned word (WIDTH >= 2)
CNT_W, 4, width of hit counter; must satisfy 2^CNT_W > WIDTH-1

Ports:
clk  in  1  clock, all state on rising edge
_rst  in  1  reset, asynchronous, active-low
start  in  1  request scan of data_in; honoured only when ready=1
abort  in  1  synchronous cancel of a scan in progress
data_in  in  WIDTH  word to scan, sampled on the accepting edge only
ready  out  1  controller idle, start will be accepted
busy  out  1  scan in progress (SHIFT state)
done  out  1  one-cycle pulse: scan complete, hits valid
hits  out  CNT_W  number of "11" occurrences in last word (overlapping)
found  out  1  hits != 0, registered alongside hits

Behaviour:
- Reset (_rst low, asynchronous): ctrl state IDLE, detector state SAD, shift register 0, bit counter 0, hits 0, found 0, done 0, ready 1, busy 0. Reset mid-scan discards the scan; no done is generated.
- Control FSM states: IDLE, SHIFT, DONE. Encoding is free; default branch goes to IDLE.
- IDLE, start=1:
  - latch data_in into the shift register;
  - clear hits/found to 0;
  - force detector to SAD;
  - bit counter to 0;
  - go to SHIFT.
- IDLE, start=0: stay in IDLE; outputs hold.
- SHIFT, every edge:
  - current bit = shift register MSB; shift left by 1, filling 0;
  - detector next state = HOPE if in SAD and bit=1; HOORAY if in HOPE/HOORAY and bit=1; SAD if bit=0;
  - when the detector enters HOORAY, hits increments (saturating at 2^CNT_W-1) and found is set;
  - bit counter increments.
  - After the edge consuming bit index WIDTH-1 (LSB), go to DONE.
- DONE: done=1 for exactly this one cycle; next edge goes to IDLE unconditionally.
- Latency: start accepted at edge E0 -> busy high for WIDTH cycles -> done high in the cycle after edge E_WIDTH -> ready high after edge E_WIDTH+1. A scan takes WIDTH+2 cycles from start acceptance to next possible acceptance.
- Overlap rule: "111" yields 2 hits. The detector always begins each word in SAD; there is no carry-over between words.
- hits/found hold their value from DONE through IDLE until the next accepted start.
- start while busy or in DONE: ignored, not queued.
- abort=1 in SHIFT or DONE: next edge goes to IDLE, hits/found cleared to 0, no done pulse. abort in IDLE has no effect.
- start and abort both high in IDLE: start wins, because abort is meaningless in IDLE.
- ready = (state==IDLE); busy = (state==SHIFT); done = (state==DONE). All are decoded from registered state, so they are glitch-free.
- data_in changes while busy: no effect.

Test Plan:
- Reset then start with data_in=8'hFF -> busy 8 cycles, done pulse 1 cycle, hits=7, found=1.
- data_in=8'hAA (10101010) -> hits=0, found=0, done still pulses after 8 shift cycles.
- data_in=8'h66 (01100110) then immediately (first ready cycle) data_in=8'hC0 -> hits=2, then hits=1; the second word does not inherit the first word's trailing detector state.
- Start at cycle 0 with 8'hFF, pulse start again with 8'h00 at cycle 3 -> second start ignored; hits=7; ready only after done.
- Start with 8'hFF, abort at 4th shift cycle -> no done pulse, IDLE next cycle, hits=0, ready=1; _rst low mid-scan of 8'hFF -> all outputs to reset values immediately (asynchronous), no done after release.
- WIDTH=4, CNT_W=2, data_in=4'hF -> hits=3 with no overflow; cycle count from start acceptance to done = 5.
